// File: rtl/cal_angle_acc_pkg.sv
// Shared types and widths for the angle-divider front end.
package cal_angle_pkg;

    // Widths match the divider's dividend/divisor ports.
    localparam int SUM_W = 16;
    localparam int CNT_W = 8;

    localparam logic [SUM_W-1:0] SUM_MAX = {SUM_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // 17-bit add of an 8-bit sample into the sum; bit SUM_W flags saturation.
    function automatic logic [SUM_W:0] sat_add(input logic [SUM_W-1:0] sum,
                                               input logic [7:0] data);
        logic [SUM_W:0] raw;
        raw = {1'b0, sum} + {{(SUM_W-7){1'b0}}, data};
        if (raw[SUM_W])
            sat_add = {1'b1, SUM_MAX};
        else
            sat_add = raw;
    endfunction

endpackage

// File: rtl/cal_angle_acc_if.sv
// Sample stream and divider request/response bundle for cal_angle_acc.
interface cal_angle_acc_if;
    import cal_angle_pkg::*;

    logic             sample_val;
    logic [7:0]       sample_data;
    logic             sample_last;
    logic             sample_rdy;
    logic [SUM_W-1:0] dividend;
    logic [CNT_W-1:0] divisor;
    logic             div_val;
    logic             div_done;
    logic             ovf;
    logic             err;
    logic             busy;

    // Accumulator side.
    modport slave (
        input  sample_val, sample_data, sample_last, div_done,
        output sample_rdy, dividend, divisor, div_val, ovf, err, busy
    );

    // Upstream source / divider side.
    modport master (
        output sample_val, sample_data, sample_last, div_done,
        input  sample_rdy, dividend, divisor, div_val, ovf, err, busy
    );

endinterface

// File: rtl/cal_angle_acc.sv
// Window accumulator: sums and counts samples until sample_last, issues one
// divider request, then waits for div_done (or a timeout) before the next window.
module cal_angle_acc
    import cal_angle_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input logic            clk,
    input logic            rst_n,
    cal_angle_acc_if.slave bus
);

    localparam int              TMO_W    = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [SUM_W-1:0] sum, sum_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ovf_w, ovf_nxt;
    logic [TMO_W-1:0] tmo;
    logic [SUM_W:0]   add_res;
    logic             accept;
    logic             close;
    logic             tmo_hit;

    assign bus.sample_rdy = (state == ST_IDLE) || (state == ST_ACC);
    assign bus.busy       = (state == ST_ISSUE) || (state == ST_WAIT);

    assign accept  = bus.sample_val && bus.sample_rdy;
    assign close   = accept && bus.sample_last;
    assign tmo_hit = (state == ST_WAIT) && !bus.div_done && (tmo == TMO_LAST);
    assign add_res = sat_add(sum, bus.sample_data);

    // Saturating accumulator next value; computed combinationally so the
    // closing sample is already folded in when the request registers load.
    always_comb begin
        sum_nxt = sum;
        cnt_nxt = cnt;
        ovf_nxt = ovf_w;
        if (accept) begin
            if (state == ST_IDLE) begin
                sum_nxt = {{(SUM_W-8){1'b0}}, bus.sample_data};
                cnt_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
                ovf_nxt = 1'b0;
            end else if (cnt == CNT_MAX) begin
                // Count pinned: drop the sample entirely but remember it.
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
                sum_nxt = add_res[SUM_W-1:0];
                if (add_res[SUM_W])
                    ovf_nxt = 1'b1;
            end
        end
    end

    // Next-state decode; div_done wins over a coincident timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = bus.sample_last ? ST_ISSUE : ST_ACC;
            ST_ACC:   if (close)  state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (bus.div_done || tmo_hit) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State, accumulator and timeout counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sum   <= '0;
            cnt   <= '0;
            ovf_w <= 1'b0;
            tmo   <= '0;
        end else begin
            state <= state_nxt;
            sum   <= sum_nxt;
            cnt   <= cnt_nxt;
            ovf_w <= ovf_nxt;
            if (state == ST_ISSUE)
                tmo <= '0;
            else if (state == ST_WAIT && !bus.div_done && !tmo_hit)
                tmo <= tmo + 1'b1;
        end
    end

    // Registered request outputs: loaded on the edge that accepts the last
    // sample, so div_val is high during ISSUE and the operands hold after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dividend <= '0;
            bus.divisor  <= '0;
            bus.ovf      <= 1'b0;
            bus.div_val  <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            bus.div_val <= close;
            bus.err     <= tmo_hit;
            if (close) begin
                bus.dividend <= sum_nxt;
                bus.divisor  <= cnt_nxt;
                bus.ovf      <= ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_cal_angle_acc.sv
// Directed + randomized bench for cal_angle_acc with a window-level reference.
module tb_cal_angle_acc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   unsigned win[$];

    cal_angle_acc_if bus();

    cal_angle_acc #(.TIMEOUT(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: a window of n samples keeps the first min(n,255) samples,
    // sum clamps at 0xFFFF, ovf if anything was dropped or clamped.
    task automatic model(output int unsigned e_sum, output int unsigned e_cnt, output bit e_ovf);
        int unsigned s;
        int unsigned n;
        n = win.size();
        e_cnt = (n > 255) ? 255 : n;
        s = 0;
        for (int i = 0; i < int'(e_cnt); i++) s += win[i];
        e_ovf = (n > 255) || (s > 65535);
        e_sum = (s > 65535) ? 65535 : s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the queued window with random idle gaps; check the issue cycle.
    task automatic send_window(input int gap_max);
        int unsigned e_sum, e_cnt;
        bit          e_ovf;
        for (int i = 0; i < win.size(); i++) begin
            int g;
            g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            bus.sample_val = 1'b0;
            for (int k = 0; k < g; k++) begin
                tick();
                chk("rdy_gap", bus.sample_rdy, 1);
            end
            bus.sample_val  = 1'b1;
            bus.sample_data = win[i][7:0];
            bus.sample_last = (i == win.size() - 1);
            tick();
        end
        bus.sample_val  = 1'b0;
        bus.sample_last = 1'b0;
        model(e_sum, e_cnt, e_ovf);
        chk("div_val", bus.div_val, 1);
        chk("dividend", bus.dividend, e_sum);
        chk("divisor", bus.divisor, e_cnt);
        chk("ovf", bus.ovf, e_ovf);
        chk("busy_issue", bus.busy, 1);
        chk("rdy_issue", bus.sample_rdy, 0);
    endtask

    // Return div_done during WAIT cycle delay+1; optionally keep sample_val high.
    task automatic finish_div(input int delay, input bit hold);
        if (hold) begin
            bus.sample_val  = 1'b1;
            bus.sample_data = 8'd99;
            bus.sample_last = 1'b1;
        end
        tick();
        chk("div_val_pulse", bus.div_val, 0);
        chk("busy_wait", bus.busy, 1);
        if (hold) chk("rdy_hold", bus.sample_rdy, 0);
        for (int k = 0; k < delay; k++) begin
            tick();
            chk("busy_wait", bus.busy, 1);
            if (hold) chk("rdy_hold", bus.sample_rdy, 0);
        end
        bus.div_done = 1'b1;
        tick();
        bus.div_done    = 1'b0;
        bus.sample_val  = 1'b0;
        bus.sample_last = 1'b0;
        chk("rdy_after_done", bus.sample_rdy, 1);
        chk("busy_after_done", bus.busy, 0);
        chk("err_after_done", bus.err, 0);
    endtask

    initial begin
        bus.sample_val  = 1'b0;
        bus.sample_data = 8'd0;
        bus.sample_last = 1'b0;
        bus.div_done    = 1'b0;
        #12;
        chk("rst_dividend", bus.dividend, 0);
        chk("rst_divisor", bus.divisor, 0);
        chk("rst_div_val", bus.div_val, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_rdy", bus.sample_rdy, 1);
        chk("rst_busy", bus.busy, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // 10,20,30 -> 60/3
        win = {10, 20, 30};
        send_window(0);
        finish_div(2, 0);

        // Single sample 200, div_done four cycles after div_val
        win = {200};
        send_window(0);
        finish_div(3, 0);

        // 300 x 255: count pins at 255, remaining samples dropped
        win.delete();
        for (int i = 0; i < 300; i++) win.push_back(255);
        send_window(0);
        finish_div(0, 0);

        // Timeout: 60/3 window, no div_done
        win = {10, 20, 30};
        send_window(1);
        for (int k = 1; k <= 64; k++) begin
            tick();
            chk("busy_tmo", bus.busy, 1);
            chk("err_early", bus.err, 0);
        end
        tick();
        chk("err_pulse", bus.err, 1);
        chk("rdy_tmo", bus.sample_rdy, 1);
        chk("busy_tmo_end", bus.busy, 0);
        chk("dividend_hold", bus.dividend, 60);
        chk("divisor_hold", bus.divisor, 3);
        bus.div_done = 1'b1;
        tick();
        bus.div_done = 1'b0;
        chk("err_once", bus.err, 0);
        chk("idle_done_rdy", bus.sample_rdy, 1);
        chk("idle_done_busy", bus.busy, 0);
        chk("idle_done_dv", bus.div_val, 0);

        // div_done coinciding with the last WAIT cycle wins over the timeout
        win = {1, 2};
        send_window(0);
        finish_div(63, 0);
        tick();
        chk("err_coincide", bus.err, 0);

        // sample_val held through ISSUE/WAIT is not accepted
        win = {40, 41, 42};
        send_window(0);
        finish_div(5, 1);
        win = {5, 5};
        send_window(0);
        finish_div(1, 0);

        // Randomized windows
        for (int w = 0; w < 12; w++) begin
            int n;
            n = (w == 5) ? 260 : $urandom_range(20, 1);
            win.delete();
            for (int i = 0; i < n; i++) win.push_back($urandom_range(255, 0));
            send_window(2);
            finish_div($urandom_range(10, 0), $urandom_range(1, 0));
        end

        // Reset mid-window
        bus.sample_val  = 1'b1;
        bus.sample_last = 1'b0;
        bus.sample_data = 8'd50;
        tick();
        bus.sample_data = 8'd60;
        tick();
        bus.sample_val = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_dividend", bus.dividend, 0);
        chk("mid_rst_divisor", bus.divisor, 0);
        chk("mid_rst_div_val", bus.div_val, 0);
        chk("mid_rst_ovf", bus.ovf, 0);
        chk("mid_rst_err", bus.err, 0);
        chk("mid_rst_rdy", bus.sample_rdy, 1);
        chk("mid_rst_busy", bus.busy, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        win = {7};
        send_window(0);
        finish_div(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
